// File: rtl/ecc_dual_chk_pipe.sv
// Dual-lane SECDED decoder with a one-cycle output stage, lane-compare fault
// detection, saturating event counters and a comparator self-test sequencer.
module ecc_dual_chk_pipe #(
    parameter int DATA_WIDTH   = 148,
    parameter int PARITY_WIDTH = 9,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    detc_en,
    input  logic                    stat_clr,
    input  logic                    selftest_req,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_sticky,
    output logic                    dbit_sticky,
    output logic                    irq,
    output logic                    selftest_busy,
    output logic                    selftest_done,
    output logic                    selftest_pass
);
    localparam int HW = PARITY_WIDTH - 1;   // Hamming check bits; the top bit is overall parity
    localparam int LW = DATA_WIDTH + 2;     // lane result {sbit, dbit, mask}

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CHECK, ST_DONE} st_t;

    st_t  st_reg, st_next;
    logic st_mis_reg;

    // Hamming layout: check bit j sits at position 2^j, data fills the other
    // positions from 3 upward in order; overall parity covers every stored bit.
    function automatic logic [LW-1:0] lane_decode(input logic [DATA_WIDTH-1:0]   d,
                                                  input logic [PARITY_WIDTH-1:0] p,
                                                  input logic                    byp);
        logic [HW-1:0]         syn;
        logic                  ovr;
        logic [DATA_WIDTH-1:0] mask;
        int                    pos;
        syn  = p[HW-1:0];
        ovr  = ^{d, p};
        mask = '0;
        pos  = 2;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            if (d[i]) syn = syn ^ pos[HW-1:0];
        end
        pos = 2;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            mask[i] = ovr && (syn == pos[HW-1:0]);
        end
        if (byp) return '0;
        return {ovr, !ovr && (syn != '0), mask};
    endfunction

    logic [LW-1:0] lane_res [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_res[gi] = lane_decode(data_in, parity_in, bypass);
        end
    endgenerate

    // Diagnostic hook for flipping lane-1 mask bit 0 outside the self-test.
    logic diag_flip;
    assign diag_flip = 1'b0;

    logic                  inj_beat;
    logic [LW-1:0]         lane1_cmp;
    logic                  mismatch;
    logic                  sbit_n, dbit_n, fault_n;
    logic [DATA_WIDTH-1:0] data_next;

    assign inj_beat  = (st_reg == ST_ARM) && in_valid;
    assign lane1_cmp = lane_res[1] ^ {{(LW-1){1'b0}}, inj_beat | diag_flip};
    assign mismatch  = (lane_res[0] != lane1_cmp);
    assign sbit_n    = lane_res[0][LW-1];
    assign dbit_n    = lane_res[0][LW-2];
    assign fault_n   = detc_en && mismatch && !inj_beat;
    // The injected mismatch is artificial, so that beat still takes lane-0 data.
    assign data_next = (!mismatch || !detc_en || inj_beat)
                     ? (data_in ^ lane_res[0][DATA_WIDTH-1:0]) : data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            sbit_err     <= 1'b0;
            dbit_err     <= 1'b0;
            ecc_fault    <= 1'b0;
            sbit_cnt     <= '0;
            dbit_cnt     <= '0;
            fault_cnt    <= '0;
            fault_sticky <= 1'b0;
            dbit_sticky  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= data_next;
                sbit_err  <= sbit_n;
                dbit_err  <= dbit_n;
                ecc_fault <= fault_n;
            end
            if (stat_clr) begin
                sbit_cnt     <= '0;
                dbit_cnt     <= '0;
                fault_cnt    <= '0;
                fault_sticky <= 1'b0;
                dbit_sticky  <= 1'b0;
            end else if (in_valid) begin
                if (sbit_n && (sbit_cnt != '1))   sbit_cnt  <= sbit_cnt + CNT_WIDTH'(1);
                if (dbit_n && (dbit_cnt != '1))   dbit_cnt  <= dbit_cnt + CNT_WIDTH'(1);
                if (fault_n && (fault_cnt != '1)) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
                if (fault_n) fault_sticky <= 1'b1;
                if (dbit_n)  dbit_sticky  <= 1'b1;
            end
        end
    end

    assign irq = fault_sticky | dbit_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg        <= ST_IDLE;
            st_mis_reg    <= 1'b0;
            selftest_pass <= 1'b0;
        end else begin
            st_reg <= st_next;
            if (inj_beat) st_mis_reg <= mismatch && detc_en;
            if ((st_reg == ST_IDLE) && selftest_req) selftest_pass <= 1'b0;
            else if (st_reg == ST_CHECK)             selftest_pass <= st_mis_reg;
        end
    end

    always_comb begin
        st_next = st_reg;
        case (st_reg)
            ST_IDLE:  if (selftest_req) st_next = ST_ARM;
            ST_ARM:   if (in_valid) st_next = ST_CHECK;
            ST_CHECK: st_next = ST_DONE;
            ST_DONE:  st_next = ST_IDLE;
            default:  st_next = ST_IDLE;
        endcase
    end

    assign selftest_busy = (st_reg == ST_ARM) || (st_reg == ST_CHECK);
    assign selftest_done = (st_reg == ST_DONE);

endmodule

// File: tb/tb_ecc_dual_chk_pipe.sv
// Directed/randomised bench for ecc_dual_chk_pipe with a bit-flip based reference model.
module tb_ecc_dual_chk_pipe;
    localparam int DW   = 148;
    localparam int PW   = 9;
    localparam int CW   = 8;
    localparam int HW   = PW - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk, rst_n, in_valid, bypass, detc_en, stat_clr, selftest_req;
    logic [DW-1:0] data_in, data_out;
    logic [PW-1:0] parity_in;
    logic          out_valid, sbit_err, dbit_err, ecc_fault;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic          fault_sticky, dbit_sticky, irq;
    logic          selftest_busy, selftest_done, selftest_pass;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_sc, m_dc, m_fc;
    logic          m_fs, m_ds, m_sb, m_db, m_flt;
    logic [DW-1:0] m_data;

    ecc_dual_chk_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .parity_in(parity_in), .bypass(bypass), .detc_en(detc_en),
        .stat_clr(stat_clr), .selftest_req(selftest_req), .out_valid(out_valid),
        .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
        .ecc_fault(ecc_fault), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
        .fault_cnt(fault_cnt), .fault_sticky(fault_sticky), .dbit_sticky(dbit_sticky),
        .irq(irq), .selftest_busy(selftest_busy), .selftest_done(selftest_done),
        .selftest_pass(selftest_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = 1'($urandom);
        return w;
    endfunction

    // Build the codeword by position, then derive each check bit from its coverage set.
    function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
        logic          cw [0:511];
        logic [PW-1:0] p;
        int            k;
        k = 0;
        p = '0;
        for (int pos = 0; pos < 512; pos++) cw[pos] = 1'b0;
        for (int pos = 1; pos <= DW + HW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < HW; j++)
            for (int pos = 1; pos <= DW + HW; pos++)
                if (((pos >> j) & 1) == 1) p[j] = p[j] ^ cw[pos];
        p[HW] = (^d) ^ (^p[HW-1:0]);
        return p;
    endfunction

    task automatic model_reset();
        m_sc = 0; m_dc = 0; m_fc = 0;
        m_fs = 1'b0; m_ds = 1'b0; m_sb = 1'b0; m_db = 1'b0; m_flt = 1'b0;
        m_data = '0;
    endtask

    task automatic check_all(input string tag, input logic exp_ov);
        chk_b({tag, ".out_valid"}, out_valid, exp_ov);
        chk_d({tag, ".data_out"}, data_out, m_data);
        chk_b({tag, ".sbit_err"}, sbit_err, m_sb);
        chk_b({tag, ".dbit_err"}, dbit_err, m_db);
        chk_b({tag, ".ecc_fault"}, ecc_fault, m_flt);
        chk_c({tag, ".sbit_cnt"}, sbit_cnt, CW'(m_sc));
        chk_c({tag, ".dbit_cnt"}, dbit_cnt, CW'(m_dc));
        chk_c({tag, ".fault_cnt"}, fault_cnt, CW'(m_fc));
        chk_b({tag, ".fault_sticky"}, fault_sticky, m_fs);
        chk_b({tag, ".dbit_sticky"}, dbit_sticky, m_ds);
        chk_b({tag, ".irq"}, irq, m_fs | m_ds);
    endtask

    // One clock: optionally present a beat, advance, update the model, check everything.
    task automatic cycle(input string tag, input logic valid, input logic [DW-1:0] din,
                         input logic [PW-1:0] pin, input logic [DW-1:0] exp_d,
                         input logic sb, input logic db, input logic flt);
        logic clr;
        clr       = stat_clr;
        in_valid  = valid;
        data_in   = din;
        parity_in = pin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (valid) begin
            m_data = exp_d; m_sb = sb; m_db = db; m_flt = flt;
        end
        if (clr) begin
            m_sc = 0; m_dc = 0; m_fc = 0; m_fs = 1'b0; m_ds = 1'b0;
        end else if (valid) begin
            if (sb && m_sc < MAXC) m_sc++;
            if (db && m_dc < MAXC) m_dc++;
            if (flt && m_fc < MAXC) m_fc++;
            if (flt) m_fs = 1'b1;
            if (db)  m_ds = 1'b1;
        end
        check_all(tag, valid);
    endtask

    initial begin
        logic [DW-1:0] d, w;
        logic [PW-1:0] p;
        int            k;

        rst_n = 1'b1; in_valid = 1'b0; data_in = '0; parity_in = '0;
        bypass = 1'b0; detc_en = 1'b1; stat_clr = 1'b0; selftest_req = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        check_all("reset", 1'b0);
        chk_b("reset.busy", selftest_busy, 1'b0);
        chk_b("reset.pass", selftest_pass, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clean word, then an idle cycle that must hold data and flags
        d = rand_word();
        cycle("clean", 1'b1, d, encode(d), d, 1'b0, 1'b0, 1'b0);
        cycle("idle_hold", 1'b0, rand_word(), '0, '0, 1'b0, 1'b0, 1'b0);

        // bit 5, then random single-bit data errors and a parity-bit error
        d = rand_word(); w = d; w[5] = ~w[5];
        cycle("sbit5", 1'b1, w, encode(d), d, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            d = rand_word(); w = d; k = $urandom_range(DW - 1, 0); w[k] = ~w[k];
            cycle("sbit_rand", 1'b1, w, encode(d), d, 1'b1, 1'b0, 1'b0);
        end
        d = rand_word(); p = encode(d); k = $urandom_range(PW - 1, 0); p[k] = ~p[k];
        cycle("sbit_par", 1'b1, d, p, d, 1'b1, 1'b0, 1'b0);

        // double error: uncorrectable, passed through unchanged
        d = rand_word(); w = d; w[5] = ~w[5]; w[9] = ~w[9];
        cycle("dbit59", 1'b1, w, encode(d), w, 1'b0, 1'b1, 1'b0);

        // bypass: raw data, no flags
        bypass = 1'b1;
        d = rand_word(); w = d; w[17] = ~w[17];
        cycle("bypass", 1'b1, w, encode(d), w, 1'b0, 1'b0, 1'b0);
        bypass = 1'b0;

        stat_clr = 1'b1;
        cycle("clr_idle", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        stat_clr = 1'b0;

        // forced lane disagreement
        force dut.diag_flip = 1'b1;
        d = rand_word(); w = d; w[40] = ~w[40];
        cycle("fault_det", 1'b1, w, encode(d), w, 1'b1, 1'b0, 1'b1);
        detc_en = 1'b0;
        cycle("fault_nodet", 1'b1, w, encode(d), d, 1'b1, 1'b0, 1'b0);
        detc_en = 1'b1;
        release dut.diag_flip;
        stat_clr = 1'b1;
        cycle("clr_idle2", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        stat_clr = 1'b0;

        // saturation over 300 single-bit beats, clear coincident with beat 301
        for (int i = 0; i < 300; i++) begin
            d = rand_word(); w = d; k = $urandom_range(DW - 1, 0); w[k] = ~w[k];
            cycle("sat", 1'b1, w, encode(d), d, 1'b1, 1'b0, 1'b0);
        end
        chk_c("sat_final", sbit_cnt, CW'(MAXC));
        stat_clr = 1'b1;
        d = rand_word(); w = d; w[3] = ~w[3];
        cycle("sat_clr", 1'b1, w, encode(d), d, 1'b1, 1'b0, 1'b0);
        stat_clr = 1'b0;

        // self-test with detection enabled
        selftest_req = 1'b1;
        cycle("st_req", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        selftest_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_b("st_arm.busy", selftest_busy, 1'b1);
            chk_b("st_arm.done", selftest_done, 1'b0);
            cycle("st_arm_idle", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        d = rand_word();
        cycle("st_beat", 1'b1, d, encode(d), d, 1'b0, 1'b0, 1'b0);
        chk_b("st_check.busy", selftest_busy, 1'b1);
        chk_b("st_check.done", selftest_done, 1'b0);
        cycle("st_c1", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_b("st_done.done", selftest_done, 1'b1);
        chk_b("st_done.busy", selftest_busy, 1'b0);
        chk_b("st_done.pass", selftest_pass, 1'b1);
        cycle("st_c2", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_b("st_after.done", selftest_done, 1'b0);
        chk_b("st_after.pass", selftest_pass, 1'b1);

        // self-test with detection disabled must not pass
        selftest_req = 1'b1;
        cycle("st2_req", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        selftest_req = 1'b0;
        chk_b("st2_req.pass", selftest_pass, 1'b0);
        detc_en = 1'b0;
        d = rand_word();
        cycle("st2_beat", 1'b1, d, encode(d), d, 1'b0, 1'b0, 1'b0);
        detc_en = 1'b1;
        cycle("st2_c1", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk_b("st2_done.done", selftest_done, 1'b1);
        chk_b("st2_done.pass", selftest_pass, 1'b0);
        cycle("st2_c2", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

        // reset while armed
        d = rand_word(); w = d; w[5] = ~w[5]; w[9] = ~w[9];
        cycle("pre_rst", 1'b1, w, encode(d), w, 1'b0, 1'b1, 1'b0);
        selftest_req = 1'b1;
        cycle("rst_arm_req", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        selftest_req = 1'b0;
        chk_b("rst_arm.busy", selftest_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async", 1'b0);
        chk_b("rst_async.busy", selftest_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("post_rst", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
            chk_b("post_rst.done", selftest_done, 1'b0);
            chk_b("post_rst.busy", selftest_busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecc_dual_chk_pipe.md
ECC_DUAL_CHK_PIPE -- requirements
Module: ecc_dual_chk_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 148, protected data width; legal 8..512.
REQ-002 Parameter PARITY_WIDTH, default 9, SECDED check bits; SHALL satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 8, width of each event counter.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  beat qualifier for data_in/parity_in.
REQ-007 data_in  in  DATA_WIDTH  stored data word.
REQ-008 parity_in  in  PARITY_WIDTH  stored check bits.
REQ-009 bypass  in  1  1 = no correction, no error flags.
REQ-010 detc_en  in  1  enables lane-compare fault detection.
REQ-011 stat_clr  in  1  single-cycle pulse, clears counters and sticky flags.
REQ-012 selftest_req  in  1  single-cycle pulse, starts comparator self-test.
REQ-013 out_valid  out  1  registered in_valid.
REQ-014 data_out  out  DATA_WIDTH  corrected or raw data.
REQ-015 sbit_err / dbit_err / ecc_fault  out  1 each  per-beat flags, valid when out_valid=1.
REQ-016 sbit_cnt / dbit_cnt / fault_cnt  out  CNT_WIDTH each  saturating event counters.
REQ-017 fault_sticky, dbit_sticky, irq  out  1 each  status; irq = fault_sticky | dbit_sticky.
REQ-018 selftest_busy, selftest_done, selftest_pass  out  1 each  self-test status.

Function
REQ-019 Two identical SECDED decode lanes SHALL process data_in/parity_in/bypass combinationally; each yields correction mask, sbit, dbit.
REQ-020 Lanes compare when {sbit,dbit,mask} equal bitwise; mismatch with detc_en=1 is a lane fault.
REQ-021 Latency exactly 1 cycle: beat accepted on in_valid=1 at edge N appears at edge N+1 with out_valid=1.
REQ-022 data_out = lane-0 corrected data if compare true or detc_en=0; else raw data_in.
REQ-023 sbit_err/dbit_err SHALL come from lane 0; with bypass=1 both 0.
REQ-024 When in_valid=0, out_valid=0 next cycle; data_out and flags hold prior values; counters unchanged.
REQ-025 Each counter increments by 1 per valid beat with its flag set and saturates at 2^CNT_WIDTH-1 (no wrap).
REQ-026 fault_sticky/dbit_sticky set on a valid beat with ecc_fault/dbit_err; held until stat_clr or reset.
REQ-027 stat_clr coincident with an increment/set: clear wins, result 0.
REQ-028 Self-test FSM states IDLE, ARM, CHECK, DONE; reset state IDLE.
REQ-029 IDLE->ARM on selftest_req; selftest_req in any other state ignored.
REQ-030 ARM: wait for in_valid=1; on that beat invert lane-1 mask bit 0 before compare; ->CHECK.
REQ-031 Injected beat: data_out = lane-0 corrected data; ecc_fault output 0; fault_cnt and fault_sticky not updated.
REQ-032 CHECK (1 cycle): selftest_pass <= internal mismatch of injected beat AND detc_en at that beat; ->DONE.
REQ-033 DONE: selftest_done=1 for exactly one cycle; ->IDLE; selftest_pass holds until next selftest_req.
REQ-034 selftest_busy=1 in ARM and CHECK.
REQ-035 stat_clr does not affect FSM or selftest_pass.

Reset
REQ-036 rst_n low asynchronously: all outputs 0, counters 0, sticky 0, FSM IDLE; beat in flight discarded.
REQ-037 Reset deassertion mid-self-test resumes at IDLE; no selftest_done pulse.

Verification
REQ-038 Clean word, parity correct, in_valid=1 one cycle -> next cycle out_valid=1, data_out=data_in, all flags 0, counters 0.
REQ-039 Flip data bit 5 -> data_out bit 5 restored, sbit_err=1, sbit_cnt=1; flip bits 5 and 9 -> dbit_err=1, dbit_cnt=1, irq=1.
REQ-040 Force lane-1 mask mismatch, detc_en=1 -> data_out=raw data_in, ecc_fault=1, fault_cnt=1, irq=1; detc_en=0 -> ecc_fault=0, corrected data.
REQ-041 CNT_WIDTH=8, 300 single-bit-error beats -> sbit_cnt=255; stat_clr same cycle as beat 301 -> sbit_cnt=0.
REQ-042 selftest_req, idle 3 cycles, then one clean beat -> busy during ARM/CHECK, done pulse 2 cycles after beat, pass=1, fault_cnt=0, ecc_fault=0.
REQ-043 rst_n low while FSM in ARM -> all outputs 0 immediately, FSM IDLE, no done pulse after release.
